// File: rtl/whack_pkg.sv
// Shared types and constants for the Whack score keeper.
// Holds the round state encoding and the score saturation helper.
package whack_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam int SCORE_W = 8;
   localparam int SECS_W  = 6;

   // Clamp a 9-bit intermediate score to the configured ceiling
   function automatic logic [SCORE_W-1:0] sat_score(
      input logic [SCORE_W:0] value,
      input logic [SCORE_W:0] ceiling
   );
      logic [SCORE_W:0] v;
      if (value > ceiling) begin
         v = ceiling;
      end else begin
         v = value;
      end
      return v[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/whack_round_timer.sv
// Round timer: one-second tick divider feeding a seconds-left down-counter.
// o_done is high on the wrap that takes secs_left from 1 to 0.
module whack_round_timer
   import whack_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned ROUND_SECS = 30
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_en,
   output logic [SECS_W-1:0] o_secs_left,
   output logic              o_done
);

   localparam int unsigned       TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] r_tick;
   logic [SECS_W-1:0] r_secs;
   logic              w_wrap;

   assign w_wrap      = (r_tick == TICK_MAX);
   assign o_done      = i_en & w_wrap & (r_secs == SECS_W'(1));
   assign o_secs_left = r_secs;

   // Tick divider and seconds counter; load restarts a full round
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tick <= '0;
         r_secs <= '0;
      end else if (i_load) begin
         r_tick <= '0;
         r_secs <= SECS_W'(ROUND_SECS);
      end else if (i_en) begin
         if (w_wrap) begin
            r_tick <= '0;
            if (r_secs != '0) begin
               r_secs <= r_secs - SECS_W'(1);
            end
         end else begin
            r_tick <= r_tick + TICK_W'(1);
         end
      end
   end

endmodule

// File: rtl/whack_score_keeper.sv
// Whack score engine: round FSM, saturating score and session high score.
// Optional MISS_PENALTY_EN: a missed mole takes one point off the score.
module whack_score_keeper
   import whack_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned ROUND_SECS = 30,
   parameter int unsigned MAX_SCORE  = 99,
   parameter int unsigned HIT_PTS    = 1
) (
   input  logic               Clock,
   input  logic               reset,
   input  logic               start,
   input  logic               hit,
   input  logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic [SECS_W-1:0]  secs_left,
   output logic               playing,
   output logic               game_over
);

   state_t             r_state;
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W-1:0] r_high_score;
   logic               r_playing;
   logic               r_game_over;
   logic               r_start_q;
   logic               r_hit_q;

   logic               w_start_rise;
   logic               w_hit_rise;
   logic               w_load;
   logic               w_en;
   logic               w_done;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_score_next;

   assign w_start_rise = start & ~r_start_q;
   assign w_hit_rise   = hit & ~r_hit_q;
   assign w_load       = w_start_rise & ((r_state == S_IDLE) | (r_state == S_OVER));
   assign w_en         = (r_state == S_PLAY);

`ifdef MISS_PENALTY_EN
   logic r_miss_q;
   logic w_miss_rise;
   assign w_miss_rise = miss & ~r_miss_q;

   // Miss edge history
   always_ff @(posedge Clock) begin
      if (!reset) begin
         r_miss_q <= 1'b0;
      end else begin
         r_miss_q <= miss;
      end
   end
`else
   logic w_unused_miss;
   assign w_unused_miss = miss;
`endif

   whack_round_timer #(
      .TICK_DIV   (TICK_DIV),
      .ROUND_SECS (ROUND_SECS)
   ) u_timer (
      .i_clk       (Clock),
      .i_rst_n     (reset),
      .i_load      (w_load),
      .i_en        (w_en),
      .o_secs_left (secs_left),
      .o_done      (w_done)
   );

   // Next score: add in 9 bits, apply any penalty, then clamp to the ceiling
   always_comb begin
      w_sum = {1'b0, r_score};
      if (w_hit_rise) begin
         w_sum = w_sum + (SCORE_W + 1)'(HIT_PTS);
      end else begin
         w_sum = w_sum;
      end
`ifdef MISS_PENALTY_EN
      if (w_miss_rise && (w_sum != '0)) begin
         w_sum = w_sum - (SCORE_W + 1)'(1);
      end else begin
         w_sum = w_sum;
      end
`endif
      w_score_next = sat_score(w_sum, (SCORE_W + 1)'(MAX_SCORE));
   end

   // Round FSM with score, high score and status flags decoded from the next state
   always_ff @(posedge Clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_score      <= '0;
         r_high_score <= '0;
         r_playing    <= 1'b0;
         r_game_over  <= 1'b0;
         r_start_q    <= 1'b0;
         r_hit_q      <= 1'b0;
      end else begin
         r_start_q <= start;
         r_hit_q   <= hit;
         case (r_state)
            S_IDLE, S_OVER: begin
               if (w_start_rise) begin
                  r_state     <= S_PLAY;
                  r_score     <= '0;
                  r_playing   <= 1'b1;
                  r_game_over <= 1'b0;
               end
            end
            S_PLAY: begin
               r_score <= w_score_next;
               if (w_done) begin
                  r_state     <= S_OVER;
                  r_playing   <= 1'b0;
                  r_game_over <= 1'b1;
                  // Final-cycle hit is already folded into w_score_next
                  if (w_score_next > r_high_score) begin
                     r_high_score <= w_score_next;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_playing   <= 1'b0;
               r_game_over <= 1'b0;
            end
         endcase
      end
   end

   assign score      = r_score;
   assign high_score = r_high_score;
   assign playing    = r_playing;
   assign game_over  = r_game_over;

endmodule
